// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake CDC sender: the controller
// state encoding and a helper that sizes counters from a cycle count.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    // Bits needed to hold values 0..cycles; never less than one bit so a
    // zero count still yields a legal vector.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cdc_sync.sv
// Standard two-flop synchroniser. The d input is asynchronous to clk and is
// the target of a false-path constraint in the timing setup; q is the only
// copy of it that downstream logic may look at.
module cdc_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdc_toggle_sender.sv
// Sending side of a two-phase (toggle) request/acknowledge CDC handshake.
// A word is captured into data_out, held stable for SETUP_CYCLES, then req
// toggles. The far domain samples data_out and echoes req on ack_async; once
// the synchronised ack matches req the word is complete and done pulses.
// Timeouts and acks that arrive when none is expected raise a sticky err.
module cdc_toggle_sender
    import cdc_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             req,
    input  logic             ack_async,
    output logic             done,
    output logic             err,
    input  logic             err_clear
);

    localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
    localparam int SU_W = cnt_width(SETUP_CYCLES);

    // Saturation value of the timeout counter and the value just below it,
    // at which the next WAIT_ACK cycle reaches the limit.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_PRE  = TO_W'(TIMEOUT_CYCLES - 1);

    // SETUP counts down from SETUP_CYCLES-1 so req toggles exactly
    // SETUP_CYCLES edges after the accept edge.
    localparam logic [SU_W-1:0] SU_LOAD = SU_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);

    state_t          state;
    logic            ack_s;
    logic [SU_W-1:0] setup_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            spurious;
    logic            timeout_hit;

    cdc_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack_async),
        .q     (ack_s)
    );

    assign in_ready = (state == IDLE);

    // Handshake controller: capture, setup hold, toggle req, wait for the echo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_out  <= '0;
            req       <= 1'b0;
            done      <= 1'b0;
            setup_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_out <= in_data;
                        if (SETUP_CYCLES == 0) begin
                            req    <= ~req;
                            to_cnt <= '0;
                            state  <= WAIT_ACK;
                        end else begin
                            setup_cnt <= SU_LOAD;
                            state     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (setup_cnt == '0) begin
                        req    <= ~req;
                        to_cnt <= '0;
                        state  <= WAIT_ACK;
                    end else begin
                        setup_cnt <= setup_cnt - 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s == req) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if ((TIMEOUT_CYCLES != 0) && (to_cnt != TO_LAST)) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Error sources: an ack edge when no request is outstanding, or the wait
    // counter stepping onto the timeout limit (only once, as it then saturates).
    always_comb begin
        spurious    = (state != WAIT_ACK) && (ack_s != req);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (state == WAIT_ACK) &&
                      (ack_s != req) && (to_cnt == TO_PRE);
    end

    // Sticky error flag; a clear request wins over a same-cycle new error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_clear) begin
            err <= 1'b0;
        end else if (spurious || timeout_hit) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdc_toggle_sender.sv
// Directed bench for cdc_toggle_sender. The main instance uses SETUP=2,
// TIMEOUT=16 with a small far-end model; a second instance uses SETUP=0,
// TIMEOUT=4 to cover the zero-setup path and err_clear priority.
module tb_cdc_toggle_sender;

    localparam int RESP_DLY = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] data_out;
    logic       req;
    logic       ack_async = 1'b0;
    logic       done;
    logic       err;
    logic       err_clear = 1'b0;

    logic       in_valid_z = 1'b0;
    logic [7:0] in_data_z = 8'h00;
    logic       in_ready_z;
    logic [7:0] data_out_z;
    logic       req_z;
    logic       ack_z = 1'b0;
    logic       done_z;
    logic       err_z;
    logic       err_clear_z = 1'b0;

    int         checks = 0;
    int         fails = 0;
    logic       exp_req = 1'b0;

    logic       resp_en = 1'b0;
    int         resp_cnt = 0;
    logic [7:0] rx_q[$];

    cdc_toggle_sender #(
        .WIDTH          (8),
        .SETUP_CYCLES   (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .req       (req),
        .ack_async (ack_async),
        .done      (done),
        .err       (err),
        .err_clear (err_clear)
    );

    cdc_toggle_sender #(
        .WIDTH          (8),
        .SETUP_CYCLES   (0),
        .TIMEOUT_CYCLES (4)
    ) dut_z (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_z),
        .in_data   (in_data_z),
        .in_ready  (in_ready_z),
        .data_out  (data_out_z),
        .req       (req_z),
        .ack_async (ack_z),
        .done      (done_z),
        .err       (err_z),
        .err_clear (err_clear_z)
    );

    always #5 clk = ~clk;

    // One clock; sample 1 ns after the edge, then let the far-end model act.
    task automatic step();
        @(posedge clk);
        #1;
        if (resp_en) begin
            if (req !== ack_async) begin
                if (resp_cnt == 0) begin
                    rx_q.push_back(data_out);
                    ack_async = ~ack_async;
                    resp_cnt  = RESP_DLY;
                end else begin
                    resp_cnt = resp_cnt - 1;
                end
            end else begin
                resp_cnt = RESP_DLY;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b expected 0", req); end
        checks++; if (data_out !== 8'h00) begin fails++; $display("[TB] FAIL reset_data_out: got %h expected 00", data_out); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin fails++; $display("[TB] FAIL reset_done_err: got %b%b expected 00", done, err); end
        checks++; if (in_ready_z !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready_z: got %b expected 1", in_ready_z); end
        step(); step(); step();
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || req !== 1'b0 || err !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_idle: got rdy=%b req=%b err=%b expected 1 0 0", in_ready, req, err); end
    endtask

    task automatic test_single();
        int ndone;
        ndone = 0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_data = 8'hFF;
        checks++; if (data_out !== 8'hA5) begin fails++; $display("[TB] FAIL single_capture: got %h expected a5", data_out); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL single_busy: got %b expected 0", in_ready); end
        checks++; if (req !== 1'b0) begin fails++; $display("[TB] FAIL single_req_n0: got %b expected 0", req); end
        for (int c = 1; c <= 10; c++) begin
            step();
            if (done === 1'b1) ndone++;
            checks++; if (req !== (c >= 2)) begin fails++; $display("[TB] FAIL single_req c=%0d: got %b expected %b", c, req, (c >= 2)); end
            checks++; if (done !== (c == 8)) begin fails++; $display("[TB] FAIL single_done c=%0d: got %b expected %b", c, done, (c == 8)); end
            checks++; if (data_out !== 8'hA5) begin fails++; $display("[TB] FAIL single_hold c=%0d: got %h expected a5", c, data_out); end
            checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL single_err c=%0d: got %b expected 0", c, err); end
            if (c == 5) ack_async = 1'b1;
            if (c == 7) in_valid = 1'b0;
        end
        exp_req = ~exp_req;
        checks++; if (ndone != 1) begin fails++; $display("[TB] FAIL single_pulses: got %0d expected 1", ndone); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        int         idx;
        int         ndone;
        int         ntog;
        logic       prev_req;
        logic       acc;
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        idx = 0; ndone = 0; ntog = 0;
        prev_req = exp_req;
        rx_q.delete();
        resp_cnt = RESP_DLY;
        resp_en  = 1'b1;
        in_valid = 1'b1;
        in_data  = words[0];
        for (int c = 0; c < 200 && !(idx == 3 && ndone == 3); c++) begin
            acc = in_valid && in_ready;
            if (acc && idx > 0) begin
                checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept_on_done word=%0d: got done=%b expected 1", idx, done); end
            end
            step();
            if (done === 1'b1) begin
                ndone++;
                checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready_with_done: got %b expected 1", in_ready); end
            end
            if (req !== prev_req) ntog++;
            prev_req = req;
            if (acc) begin
                idx++;
                if (idx < 3) in_data = words[idx];
                else in_valid = 1'b0;
            end
        end
        resp_en = 1'b0;
        checks++; if (ndone != 3) begin fails++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", ndone); end
        checks++; if (ntog != 3) begin fails++; $display("[TB] FAIL b2b_req_toggles: got %0d expected 3", ntog); end
        checks++; if (rx_q.size() != 3) begin fails++; $display("[TB] FAIL b2b_rx_count: got %0d expected 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== words[i]) begin fails++; $display("[TB] FAIL b2b_rx word=%0d: got %h expected %h", i, rx_q[i], words[i]); end
        end
        exp_req = ~exp_req;
        exp_req = ~exp_req;
        exp_req = ~exp_req;
    endtask

    task automatic test_timeout();
        in_valid = 1'b1;
        in_data  = 8'h42;
        step();
        in_valid = 1'b0;
        step();
        step();
        exp_req = ~exp_req;
        checks++; if (req !== exp_req) begin fails++; $display("[TB] FAIL timeout_req_toggle: got %b expected %b", req, exp_req); end
        for (int c = 1; c <= 18; c++) begin
            step();
            checks++; if (err !== (c >= 16)) begin fails++; $display("[TB] FAIL timeout_err c=%0d: got %b expected %b", c, err, (c >= 16)); end
            checks++; if (in_ready !== 1'b0 || req !== exp_req) begin fails++; $display("[TB] FAIL timeout_wait c=%0d: got rdy=%b req=%b expected 0 %b", c, in_ready, req, exp_req); end
        end
        ack_async = ~ack_async;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (done !== (k == 3)) begin fails++; $display("[TB] FAIL timeout_late_done k=%0d: got %b expected %b", k, done, (k == 3)); end
        end
        checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL timeout_sticky: got %b expected 1", err); end
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL timeout_clear: got %b expected 0", err); end
        step(); step(); step();
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL timeout_stays_clear: got %b expected 0", err); end
    endtask

    task automatic test_spurious();
        int ndone;
        ndone = 0;
        ack_async = ~ack_async;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (err !== (k == 3)) begin fails++; $display("[TB] FAIL spurious_err k=%0d: got %b expected %b", k, err, (k == 3)); end
            checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL spurious_ready k=%0d: got %b expected 1", k, in_ready); end
        end
        ack_async = ~ack_async;
        step(); step(); step(); step();
        checks++; if (err !== 1'b1 || req !== exp_req) begin fails++; $display("[TB] FAIL spurious_state: got err=%b req=%b expected 1 %b", err, req, exp_req); end
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        rx_q.delete();
        resp_cnt = RESP_DLY;
        resp_en  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 40 && ndone == 0; c++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        resp_en = 1'b0;
        exp_req = ~exp_req;
        checks++; if (ndone != 1) begin fails++; $display("[TB] FAIL spurious_next_done: got %0d expected 1", ndone); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin fails++; $display("[TB] FAIL spurious_next_rx: got n=%0d expected one word 5a", rx_q.size()); end
        checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL spurious_next_err: got %b expected 0", err); end
    endtask

    task automatic test_reset_mid_wait();
        int ndone;
        ndone = 0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        ack_async = 1'b0;
        #1;
        checks++; if (req !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_req: got %b expected 0", req); end
        checks++; if (data_out !== 8'h00) begin fails++; $display("[TB] FAIL rst_mid_data: got %h expected 00", data_out); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", in_ready); end
        step(); step();
        rst_n = 1'b1;
        exp_req = 1'b0;
        rx_q.delete();
        resp_cnt = RESP_DLY;
        resp_en  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || data_out !== 8'h3C) begin fails++; $display("[TB] FAIL rst_first_accept: got rdy=%b data=%h expected 0 3c", in_ready, data_out); end
        for (int c = 0; c < 40 && ndone == 0; c++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        resp_en = 1'b0;
        exp_req = ~exp_req;
        checks++; if (ndone != 1) begin fails++; $display("[TB] FAIL rst_after_done: got %0d expected 1", ndone); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin fails++; $display("[TB] FAIL rst_after_rx: got n=%0d expected one word 3c", rx_q.size()); end
        checks++; if (req !== exp_req) begin fails++; $display("[TB] FAIL rst_after_req: got %b expected %b", req, exp_req); end
    endtask

    task automatic test_setup_zero();
        in_valid_z = 1'b1;
        in_data_z  = 8'h99;
        step();
        in_valid_z = 1'b0;
        checks++; if (req_z !== 1'b1) begin fails++; $display("[TB] FAIL z_req_at_accept: got %b expected 1", req_z); end
        checks++; if (data_out_z !== 8'h99 || in_ready_z !== 1'b0) begin fails++; $display("[TB] FAIL z_capture: got data=%h rdy=%b expected 99 0", data_out_z, in_ready_z); end
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++; if (err_z !== 1'b0) begin fails++; $display("[TB] FAIL z_err_pre c=%0d: got %b expected 0", c, err_z); end
        end
        err_clear_z = 1'b1;
        step();
        err_clear_z = 1'b0;
        checks++; if (err_z !== 1'b0) begin fails++; $display("[TB] FAIL z_clear_priority: got %b expected 0", err_z); end
        step(); step(); step();
        checks++; if (err_z !== 1'b0 || in_ready_z !== 1'b0) begin fails++; $display("[TB] FAIL z_saturated: got err=%b rdy=%b expected 0 0", err_z, in_ready_z); end
        ack_z = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (done_z !== (k == 3)) begin fails++; $display("[TB] FAIL z_done k=%0d: got %b expected %b", k, done_z, (k == 3)); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_spurious();
        test_reset_mid_wait();
        test_setup_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cdc_toggle_sender.md
CDC_TOGGLE_SENDER -- requirements
Module: cdc_toggle_sender

Interface
REQ-001 Parameter WIDTH, default 8: data bus width, 1..64.
REQ-002 Parameter SETUP_CYCLES, default 2: cycles data_out is held stable before req toggles, 0..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: cycles allowed between req toggle and ack; 0 disables the timeout.
REQ-004 clk  input  1  block clock.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  1  word offered on in_data.
REQ-007 in_data  input  WIDTH  word to transfer.
REQ-008 in_ready  output  1  block can accept a word; high only in IDLE.
REQ-009 data_out  output  WIDTH  registered word presented to the far domain.
REQ-010 req  output  1  two-phase request toggle to the far domain.
REQ-011 ack_async  input  1  two-phase acknowledge toggle from the far domain; asynchronous to clk.
REQ-012 done  output  1  one-cycle pulse: far domain acknowledged the current word.
REQ-013 err  output  1  sticky error flag (timeout or spurious ack).
REQ-014 err_clear  input  1  synchronous clear of err.

Function
REQ-015 ack_async SHALL pass through a 2-flop synchroniser (reset value 0) before any use; the result is ack_s.
REQ-016 States SHALL be IDLE, SETUP, WAIT_ACK.
REQ-017 IDLE: in_valid && in_ready at edge N -> data_out <= in_data at N; next state SETUP, or WAIT_ACK with req toggled at N if SETUP_CYCLES = 0.
REQ-018 SETUP: count SETUP_CYCLES cycles; on the last, toggle req and enter WAIT_ACK; req toggles at edge N+SETUP_CYCLES.
REQ-019 data_out SHALL change only on accept in IDLE; it is stable through SETUP and WAIT_ACK.
REQ-020 WAIT_ACK: when ack_s == req, pulse done for exactly one cycle and return to IDLE; in_ready rises the same cycle done is high.
REQ-021 Back-to-back: a word offered while done is high SHALL be accepted that cycle; no lost or duplicated words.
REQ-022 Minimum round trip SHALL be SETUP_CYCLES + far-domain delay + 2 synchroniser cycles + 1.
REQ-023 Timeout: cycle counter starts at req toggle; on reaching TIMEOUT_CYCLES in WAIT_ACK, set err; the block keeps waiting, with no re-toggle and no state change.
REQ-024 Spurious ack: ack_s != req while in IDLE or SETUP SHALL set err; state is unaffected.
REQ-025 err_clear has priority over a same-cycle err set; err clears and stays clear unless a new condition occurs.
REQ-026 The timeout counter SHALL saturate (no wrap) and be WIDTH-independent: clog2(TIMEOUT_CYCLES+1) bits.
REQ-027 in_data and in_valid are ignored outside IDLE.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, data_out = 0, req = 0, ack_s and both sync flops = 0, counters = 0, done = 0, err = 0; in_ready = 1 throughout reset.
REQ-029 Reset mid-transfer SHALL abandon the word; the far end is reset by the same rst_n, so req = ack = 0 is consistent on release.
REQ-030 No output SHALL glitch on reset deassertion; first accept is possible on the first edge after release.

Structure
REQ-031 Shared package cdc_pkg SHALL hold the state enum (IDLE, SETUP, WAIT_ACK) and a function for counter width from a cycle count.
REQ-032 One sub-module: the ack synchroniser, instantiated from the team's standard synchroniser block (WIDTH=1, RESET_VAL=0); SDC false-path on its input.
REQ-033 All outputs except in_ready SHALL be registered; in_ready is decoded from state only.

Verification
REQ-034 Single word: WIDTH=8, SETUP=2, in_data=0xA5; far end acks 3 cycles after req -> req toggles at N+2, data_out=0xA5 from N+1 to done, one done pulse, err=0.
REQ-035 Back-to-back: 0x01,0x02,0x03 with in_valid held high and a model receiver -> receiver captures exactly 01,02,03 in order; three done pulses; req toggles 3 times.
REQ-036 Timeout: TIMEOUT=16, no ack -> err rises 16 cycles after the req toggle; a later ack still gives done; err_clear then clears err.
REQ-037 Spurious ack: toggle ack_async in IDLE -> err = 1 after 2-3 cycles; in_ready stays 1; next transfer completes normally once ack_s == req.
REQ-038 Reset mid-WAIT_ACK: assert rst_n low -> req = 0, data_out = 0, in_ready = 1 immediately; after release a new word 0x3C transfers correctly.
REQ-039 SETUP_CYCLES=0 and err_clear coincident with a timeout -> req toggles at the accept edge; err stays 0 that cycle.
